// File: rtl/noc_local_output_switch_pkg.sv
// Shared parameters and types for the local-port output switch.
package noc_local_output_switch_pkg;

    localparam int unsigned Noc_VC_Channel = 2;
    localparam int unsigned Noc_Flit_Width = 16;
    localparam int unsigned NOC_PORTS      = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        RELEASE = 2'd2
    } noc_vc_state_e;

    // Isolate the lowest set bit of a port-select vector.
    function automatic logic [NOC_PORTS-1:0] lowest_bit(input logic [NOC_PORTS-1:0] v);
        return v & (~v + NOC_PORTS'(1));
    endfunction

endpackage

// File: rtl/noc_local_output_switch_vc_tracker.sv
// Per-VC packet tracker: latches the granted input port, reports eligibility,
// and pulses free once the packet's tail flit has been loaded.
module noc_local_vc_tracker
    import noc_local_output_switch_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NOC_PORTS-1:0] grant_i,
    input  logic [NOC_PORTS-1:0] in_valid_i,
    input  logic [NOC_PORTS-1:0] in_tail_i,
    input  logic                 load_i,
    output logic [NOC_PORTS-1:0] sel_o,
    output logic                 eligible_c,
    output logic                 free_o
);

    noc_vc_state_e        state_q;
    logic [NOC_PORTS-1:0] sel_q;
    logic                 free_q;

    // Packet FSM; the grant head is ignored in RELEASE because it is still stale.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            free_q  <= 1'b0;
        end else begin
            free_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|grant_i) begin
                        sel_q   <= lowest_bit(grant_i);
                        state_q <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (load_i && |(in_tail_i & sel_q)) begin
                        free_q  <= 1'b1;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // VC competes for the link while forwarding and its selected port has a flit.
    always_comb begin
        eligible_c = (state_q == FORWARD) && |(in_valid_i & sel_q);
    end

    assign sel_o  = sel_q;
    assign free_o = free_q;

    // A latched grant should select exactly one port.
    assert property (@(posedge clk_i) disable iff (rst_i)
                     (state_q == IDLE && |grant_i) |-> $onehot(grant_i))
        else $warning("noc_local_vc_tracker: grant %b is not one-hot, using lowest bit", grant_i);

endmodule

// File: rtl/noc_local_output_switch.sv
// Local ejection switch: round-robin across VCs, one flit per cycle into a
// single output register, per-VC packet tracking in noc_local_vc_tracker.
module noc_local_output_switch
    import noc_local_output_switch_pkg::*;
#(
    parameter int unsigned CHANNELS   = Noc_VC_Channel,
    parameter int unsigned FLIT_WIDTH = Noc_Flit_Width
) (
    input  logic                                                noc_clk,
    input  logic                                                noc_rst,
    input  logic [CHANNELS-1:0][NOC_PORTS-1:0]                  grant_i,
    output logic [CHANNELS-1:0]                                 free_o,
    input  logic [NOC_PORTS-1:0][CHANNELS-1:0]                  in_valid,
    input  logic [NOC_PORTS-1:0][CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [NOC_PORTS-1:0][CHANNELS-1:0]                  in_tail,
    output logic [NOC_PORTS-1:0][CHANNELS-1:0]                  in_ready,
    output logic                                                out_valid,
    output logic [CHANNELS-1:0]                                 out_vc,
    output logic [FLIT_WIDTH-1:0]                               out_flit,
    output logic                                                out_tail,
    input  logic [CHANNELS-1:0]                                 out_ready
);

    localparam int unsigned VcIdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0][NOC_PORTS-1:0] vc_valid;
    logic [CHANNELS-1:0][NOC_PORTS-1:0] vc_tail;
    logic [CHANNELS-1:0][NOC_PORTS-1:0] sel;
    logic [CHANNELS-1:0]                eligible;
    logic [CHANNELS-1:0]                win_oh;
    logic [VcIdxW-1:0]                  win_idx;
    logic [VcIdxW-1:0]                  rr_ptr_q;
    logic                               any_elig;
    logic                               accepted;
    logic                               load_en;
    logic                               load_fire;
    logic [FLIT_WIDTH-1:0]              ld_flit;
    logic                               ld_tail;

    logic                               out_valid_q;
    logic [CHANNELS-1:0]                out_vc_q;
    logic [FLIT_WIDTH-1:0]              out_flit_q;
    logic                               out_tail_q;

    // Regroup port-major inputs into per-VC vectors for the trackers.
    always_comb begin
        vc_valid = '0;
        vc_tail  = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            for (int p = 0; p < NOC_PORTS; p++) begin
                vc_valid[v][p] = in_valid[p][v];
                vc_tail[v][p]  = in_tail[p][v];
            end
        end
    end

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        noc_local_vc_tracker u_tracker (
            .clk_i      (noc_clk),
            .rst_i      (noc_rst),
            .grant_i    (grant_i[v]),
            .in_valid_i (vc_valid[v]),
            .in_tail_i  (vc_tail[v]),
            .load_i     (load_fire & win_oh[v]),
            .sel_o      (sel[v]),
            .eligible_c (eligible[v]),
            .free_o     (free_o[v])
        );
    end

    // Output register handshake.
    always_comb begin
        accepted  = out_valid_q & |(out_vc_q & out_ready);
        load_en   = ~out_valid_q | accepted;
        load_fire = load_en & any_elig;
    end

    // Round-robin pick: first eligible VC at or after the priority pointer.
    always_comb begin
        int unsigned idx;
        win_oh   = '0;
        win_idx  = '0;
        any_elig = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!any_elig && eligible[VcIdxW'(idx)]) begin
                any_elig                = 1'b1;
                win_idx                 = VcIdxW'(idx);
                win_oh[VcIdxW'(idx)]    = 1'b1;
            end
        end
    end

    // Steer the winner's selected port onto the load path and acknowledge it.
    always_comb begin
        ld_flit  = '0;
        ld_tail  = 1'b0;
        in_ready = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            for (int p = 0; p < NOC_PORTS; p++) begin
                if (win_oh[v] && sel[v][p]) begin
                    ld_flit        = in_flit[p][v];
                    ld_tail        = in_tail[p][v];
                    in_ready[p][v] = load_en;
                end
            end
        end
    end

    if (CHANNELS > 1) begin : g_rr
        // Priority moves to the VC after the one just loaded.
        always_ff @(posedge noc_clk or posedge noc_rst) begin
            if (noc_rst) begin
                rr_ptr_q <= '0;
            end else if (load_fire) begin
                rr_ptr_q <= (32'(win_idx) == CHANNELS - 1) ? '0 : win_idx + VcIdxW'(1);
            end
        end
    end else begin : g_no_rr
        assign rr_ptr_q = '0;
    end

    // Single output register shared by all VCs.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            out_flit_q  <= '0;
            out_tail_q  <= 1'b0;
        end else if (load_fire) begin
            out_valid_q <= 1'b1;
            out_vc_q    <= win_oh;
            out_flit_q  <= ld_flit;
            out_tail_q  <= ld_tail;
        end else if (accepted) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_vc    = out_vc_q;
    assign out_flit  = out_flit_q;
    assign out_tail  = out_tail_q;

endmodule

// File: tb/tb_noc_local_output_switch.sv
// Scoreboard bench for noc_local_output_switch: packets are modelled as
// per-source and per-VC flit queues plus a grant FIFO per VC.
module tb_noc_local_output_switch;
    import noc_local_output_switch_pkg::*;

    localparam int unsigned C  = 2;
    localparam int unsigned FW = 16;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [C-1:0][4:0]             grant_i;
    logic [C-1:0]                  free_o;
    logic [4:0][C-1:0]             in_valid;
    logic [4:0][C-1:0][FW-1:0]     in_flit;
    logic [4:0][C-1:0]             in_tail;
    logic [4:0][C-1:0]             in_ready;
    logic                          out_valid;
    logic [C-1:0]                  out_vc;
    logic [FW-1:0]                 out_flit;
    logic                          out_tail;
    logic [C-1:0]                  out_ready;

    always #5 clk = ~clk;

    noc_local_output_switch #(.CHANNELS(C), .FLIT_WIDTH(FW)) dut (
        .noc_clk(clk), .noc_rst(rst), .grant_i(grant_i), .free_o(free_o),
        .in_valid(in_valid), .in_flit(in_flit), .in_tail(in_tail), .in_ready(in_ready),
        .out_valid(out_valid), .out_vc(out_vc), .out_flit(out_flit), .out_tail(out_tail),
        .out_ready(out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int seq     = 0;

    logic [FW:0]  src_q [5][C][$];   // {tail, flit} offered by each input port per VC
    logic [FW:0]  exp_q [C][$];      // flits expected on the link per VC, in order
    logic [4:0]   gnt_q [C][$];      // grant FIFO contents per VC
    int           free_seen [C];
    int           free_exp  [C];

    bit           force_valid, rand_ready, stall_chk, free_chk, alt_chk, timing_chk;
    int           stall_cnt, last_vc, t_tail, mon_v;
    logic [FW-1:0] held;
    logic [C-1:0] prev_free;
    logic [FW:0]  mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push_pkt(input int v, input logic [4:0] mask, input int len);
        int p;
        logic [FW-1:0] d;
        p = 0;
        for (int i = 4; i >= 0; i--) if (mask[i]) p = i;
        gnt_q[v].push_back(mask);
        free_exp[v]++;
        for (int i = 0; i < len; i++) begin
            d = FW'((v << 15) | (p << 12) | (seq & 12'hfff));
            seq++;
            src_q[p][v].push_back({(i == len - 1), d});
            exp_q[v].push_back({(i == len - 1), d});
        end
    endtask

    task automatic drive();
        for (int v = 0; v < C; v++)
            grant_i[v] = (gnt_q[v].size() > 0) ? gnt_q[v][0] : 5'b0;
        for (int p = 0; p < 5; p++) begin
            for (int v = 0; v < C; v++) begin
                if (src_q[p][v].size() > 0 && (force_valid || $urandom_range(0, 3) != 0)) begin
                    in_valid[p][v] = 1'b1;
                    {in_tail[p][v], in_flit[p][v]} = src_q[p][v][0];
                end else begin
                    in_valid[p][v] = 1'b0;
                    in_tail[p][v]  = 1'b0;
                    in_flit[p][v]  = FW'($urandom);
                end
            end
        end
        if (stall_cnt > 0) begin
            out_ready = '0;
            stall_cnt--;
        end else if (rand_ready && $urandom_range(0, 2) == 0) begin
            out_ready = C'($urandom);
        end else begin
            out_ready = '1;
        end
    endtask

    // One clock: sample handshakes mid-cycle, then retire them and drive anew.
    task automatic step();
        logic [4:0][C-1:0] rdy;
        logic [C-1:0]      fr;
        @(negedge clk);
        rdy = in_ready;
        fr  = free_o;
        check("ready_without_valid", 64'(in_ready & ~in_valid), 64'(0));
        if (stall_chk) begin
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_out_flit", 64'(out_flit), 64'(held));
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 5; p++)
            for (int v = 0; v < C; v++)
                if (rdy[p][v] && src_q[p][v].size() > 0) void'(src_q[p][v].pop_front());
        for (int v = 0; v < C; v++) begin
            if (fr[v]) begin
                if (gnt_q[v].size() > 0) void'(gnt_q[v].pop_front());
                else check("free_without_grant", 64'(v), 64'(99));
            end
        end
        drive();
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 3000; k++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                gnt_q[0].size() == 0 && gnt_q[1].size() == 0) break;
            step();
        end
        repeat (3) step();
        for (int v = 0; v < C; v++) begin
            check({name, "_exp_left"}, 64'(exp_q[v].size()), 64'(0));
            check({name, "_free_count"}, 64'(free_seen[v]), 64'(free_exp[v]));
        end
    endtask

    task automatic clear_model();
        for (int v = 0; v < C; v++) begin
            exp_q[v].delete();
            gnt_q[v].delete();
            free_seen[v] = 0;
            free_exp[v]  = 0;
            for (int p = 0; p < 5; p++) src_q[p][v].delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, 64'(out_valid), 64'(0));
        check({name, "_out_vc"},    64'(out_vc),    64'(0));
        check({name, "_out_flit"},  64'(out_flit),  64'(0));
        check({name, "_out_tail"},  64'(out_tail),  64'(0));
        check({name, "_free"},      64'(free_o),    64'(0));
        check({name, "_in_ready"},  64'(in_ready),  64'(0));
    endtask

    // Monitor: every accepted output flit is checked against its VC's queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_free = '0;
        end else begin
            cycle++;
            if (out_valid && (out_vc & out_ready) != 0) begin
                check("out_vc_onehot", 64'($onehot(out_vc)), 64'(1));
                mon_v = out_vc[1] ? 1 : 0;
                if (exp_q[mon_v].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_flit: vc %0d got %0h expected none", mon_v, {out_tail, out_flit});
                end else begin
                    mon_e = exp_q[mon_v].pop_front();
                    check("out_flit", 64'({out_tail, out_flit}), 64'(mon_e));
                end
                if (free_chk && out_tail) check("free_with_tail", 64'(free_o[mon_v]), 64'(1));
                if (alt_chk) begin
                    if (last_vc >= 0) check("rr_alternate", 64'(mon_v), 64'(1 - last_vc));
                    last_vc = mon_v;
                end
                if (timing_chk && mon_v == 0) begin
                    if (t_tail >= 0) begin
                        check("next_packet_gap", 64'(cycle - t_tail), 64'(3));
                        t_tail = -1;
                    end
                    if (out_tail) t_tail = cycle;
                end
            end
            for (int v = 0; v < C; v++) begin
                if (free_o[v]) begin
                    free_seen[v]++;
                    check("free_single_cycle", 64'(prev_free[v]), 64'(0));
                end
            end
            prev_free = free_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        force_valid = 1'b1; rand_ready = 1'b0; stall_chk = 1'b0; free_chk = 1'b0;
        alt_chk = 1'b0; timing_chk = 1'b0; stall_cnt = 0; last_vc = -1; t_tail = -1;
        held = '0;
        clear_model();
        rst = 1'b1;
        grant_i = '0; in_valid = '0; in_flit = '0; in_tail = '0; out_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        drive();

        // Single 3-flit packet, VC0 from port 2.
        free_chk = 1'b1;
        push_pkt(0, 5'b00100, 3);
        drain("single");

        // Both VCs granted together: strict VC alternation.
        alt_chk = 1'b1; last_vc = -1;
        push_pkt(0, 5'b00010, 4);
        push_pkt(1, 5'b10000, 4);
        drain("dual");
        alt_chk = 1'b0;
        free_chk = 1'b0;

        // Output stall for 5 cycles with a flit held.
        push_pkt(0, 5'b00010, 4);
        push_pkt(1, 5'b10000, 4);
        for (int k = 0; k < 20 && !out_valid; k++) step();
        check("stall_setup_valid", 64'(out_valid), 64'(1));
        held = out_flit;
        out_ready = '0;
        stall_cnt = 4;
        stall_chk = 1'b1;
        repeat (5) step();
        stall_chk = 1'b0;
        drain("stall");

        // Two queued grants on VC0; leftover port-0 flits must stay untouched.
        free_chk = 1'b1; timing_chk = 1'b1; t_tail = -1;
        push_pkt(0, 5'b00001, 2);
        src_q[0][0].push_back({1'b0, 16'hAAA0});
        src_q[0][0].push_back({1'b1, 16'hAAA1});
        push_pkt(0, 5'b01000, 3);
        drain("two_grants");
        check("port0_leftover", 64'(src_q[0][0].size()), 64'(2));
        src_q[0][0].delete();
        free_chk = 1'b0; timing_chk = 1'b0;

        // Non-one-hot grant: lowest port (1) wins, port 3 flits left alone.
        push_pkt(1, 5'b01010, 3);
        src_q[3][1].push_back({1'b1, 16'hBBB0});
        drain("multi_hot");
        check("port3_leftover", 64'(src_q[3][1].size()), 64'(1));
        src_q[3][1].delete();

        // Reset mid-packet.
        push_pkt(0, 5'b00001, 4);
        push_pkt(1, 5'b10000, 4);
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        clear_model();
        grant_i = '0; in_valid = '0; out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        push_pkt(0, 5'b00100, 2);
        drain("after_reset");

        // Randomized traffic with valid gaps and sink back-pressure.
        force_valid = 1'b0; rand_ready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            for (int v = 0; v < C; v++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++)
                    push_pkt(v, 5'(1 << $urandom_range(0, 4)), $urandom_range(1, 4));
            end
            drain("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
